// File: rtl/bin_digit_entry.sv
// Keypad front end for the BIN searcher: collects six BCD digits, drives the
// start/done handshake with a watchdog, and holds the search result for display.
module bin_digit_entry #(
  parameter int NUM_DIGITS     = 6,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  input  logic       done,
  input  logic       found,
  output logic [3:0] d5,
  output logic [3:0] d4,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic       start,
  output logic [2:0] digit_count,
  output logic       busy,
  output logic       result_valid,
  output logic       result_found,
  output logic       timeout,
  output logic       entry_error
);

  localparam logic [1:0] ENTRY   = 2'd0;
  localparam logic [1:0] LAUNCH  = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam logic [1:0] RESULT  = 2'd3;

  localparam int              WD_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]      FULL    = 3'(NUM_DIGITS);

  localparam logic [4:0] KEY_BKSP  = 5'd10;
  localparam logic [4:0] KEY_CLEAR = 5'd11;
  localparam logic [4:0] KEY_ENTER = 5'd12;

  logic [1:0]      state;
  logic [WD_W-1:0] wd_cnt;
  logic            key_valid_q;
  logic [4:0]      key_code_q;
  logic            is_digit;

  assign is_digit = key_code_q <= 5'd9;

  // Keys are registered first, so a strobe at edge n is acted on at edge n+1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ENTRY;
      wd_cnt       <= '0;
      key_valid_q  <= 1'b0;
      key_code_q   <= 5'd0;
      d5           <= 4'd0;
      d4           <= 4'd0;
      d3           <= 4'd0;
      d2           <= 4'd0;
      d1           <= 4'd0;
      d0           <= 4'd0;
      digit_count  <= 3'd0;
      start        <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_found <= 1'b0;
      timeout      <= 1'b0;
      entry_error  <= 1'b0;
    end else begin
      key_valid_q <= key_valid;
      key_code_q  <= key_code;
      entry_error <= 1'b0;
      case (state)
        ENTRY: begin
          if (key_valid_q) begin
            if (is_digit) begin
              if (digit_count == FULL) begin
                entry_error <= 1'b1;
              end else begin
                {d5, d4, d3, d2, d1, d0} <= {d4, d3, d2, d1, d0, key_code_q[3:0]};
                digit_count <= digit_count + 3'd1;
              end
            end else if (key_code_q == KEY_BKSP) begin
              if (digit_count != 3'd0) begin
                {d5, d4, d3, d2, d1, d0} <= {4'd0, d5, d4, d3, d2, d1};
                digit_count <= digit_count - 3'd1;
              end
            end else if (key_code_q == KEY_CLEAR) begin
              {d5, d4, d3, d2, d1, d0} <= 24'd0;
              digit_count <= 3'd0;
            end else if (key_code_q == KEY_ENTER) begin
              if (digit_count == FULL) begin
                state  <= LAUNCH;
                start  <= 1'b1;
                busy   <= 1'b1;
                wd_cnt <= '0;
              end else begin
                entry_error <= 1'b1;
              end
            end
          end
        end
        LAUNCH: begin
          // done has priority over a watchdog expiry in the same cycle
          if (done) begin
            result_found <= found;
            timeout      <= 1'b0;
            start        <= 1'b0;
            state        <= RELEASE;
          end else if (wd_cnt == WD_LAST) begin
            result_found <= 1'b0;
            timeout      <= 1'b1;
            start        <= 1'b0;
            state        <= RELEASE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!done) begin
            state        <= RESULT;
            result_valid <= 1'b1;
            busy         <= 1'b0;
          end
        end
        RESULT: begin
          if (key_valid_q && key_code_q <= KEY_ENTER) begin
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            if (is_digit) begin
              {d5, d4, d3, d2, d1, d0} <= {20'd0, key_code_q[3:0]};
              digit_count <= 3'd1;
              state       <= ENTRY;
            end else if (key_code_q == KEY_BKSP) begin
              if (digit_count != 3'd0) begin
                {d5, d4, d3, d2, d1, d0} <= {4'd0, d5, d4, d3, d2, d1};
                digit_count <= digit_count - 3'd1;
              end
              state <= ENTRY;
            end else if (key_code_q == KEY_CLEAR) begin
              {d5, d4, d3, d2, d1, d0} <= 24'd0;
              digit_count <= 3'd0;
              state       <= ENTRY;
            end else begin
              state  <= LAUNCH;
              start  <= 1'b1;
              busy   <= 1'b1;
              wd_cnt <= '0;
            end
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_digit_entry.sv
// Randomized and directed checks of bin_digit_entry against a digit-string model
// (entered digits kept as a queue, most recent last).
module tb_bin_digit_entry;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [4:0] key_code;
  logic       done;
  logic       found;
  logic [3:0] d5, d4, d3, d2, d1, d0;
  logic       start;
  logic [2:0] digit_count;
  logic       busy;
  logic       result_valid;
  logic       result_found;
  logic       timeout;
  logic       entry_error;

  int tests_run = 0;
  int tests_failed = 0;

  bin_digit_entry #(.NUM_DIGITS(6), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .done(done), .found(found),
    .d5(d5), .d4(d4), .d3(d3), .d2(d2), .d1(d1), .d0(d0),
    .start(start), .digit_count(digit_count), .busy(busy),
    .result_valid(result_valid), .result_found(result_found),
    .timeout(timeout), .entry_error(entry_error)
  );

  always #5 clk = ~clk;

  // model: 0 = entering, 1 = search in progress, 2 = result held
  int q[$];
  int mstate;
  bit mvalid, mfound, mtimeout, merr;

  function automatic logic [23:0] exp_digits();
    logic [23:0] v = 24'd0;
    foreach (q[i]) v = (v << 4) | 24'(q[i]);
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    mstate = 0; mvalid = 0; mfound = 0; mtimeout = 0; merr = 0;
  endtask

  task automatic model_key(input int code);
    merr = 0;
    if (mstate == 1 || code > 12) return;
    if (mstate == 2) begin
      mvalid = 0; mtimeout = 0;
      if (code <= 9) q.delete();
      mstate = (code == 12) ? 1 : 0;
      if (code == 12) return;
    end
    if (code <= 9) begin
      if (q.size() == 6) merr = 1; else q.push_back(code);
    end else if (code == 10) begin
      if (q.size() > 0) void'(q.pop_back());
    end else if (code == 11) begin
      q.delete();
    end else begin
      if (q.size() == 6) mstate = 1; else merr = 1;
    end
  endtask

  // Strobe one key; returns at the negedge after the key has taken effect.
  task automatic press(input int code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 5'(code);
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 5'($urandom_range(0, 31));
    @(negedge clk);
    model_key(code);
  endtask

  // Searcher answers a few cycles after start, then releases done.
  task automatic do_search(input bit f);
    repeat (2) @(negedge clk);
    done = 1'b1; found = f;
    @(negedge clk);
    done = 1'b0; found = 1'b0;
    @(negedge clk);
    mstate = 2; mvalid = 1; mfound = f; mtimeout = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if ({d5, d4, d3, d2, d1, d0, digit_count, start, busy, result_valid, result_found, timeout, entry_error} !== 34'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got digits=%h count=%0d start=%b busy=%b rv=%b rf=%b to=%b err=%b, expected all zero",
               {d5, d4, d3, d2, d1, d0}, digit_count, start, busy, result_valid, result_found, timeout, entry_error);
    end
  endtask

  task automatic test_overflow();
    int keys[6] = '{4, 5, 3, 2, 1, 0};
    foreach (keys[i]) press(keys[i]);
    tests_run++;
    if ({d5, d4, d3, d2, d1, d0} !== 24'h453210 || digit_count !== 3'd6) begin
      tests_failed++;
      $display("FAIL six_digits: got %h count=%0d, expected 453210 count=6", {d5, d4, d3, d2, d1, d0}, digit_count);
    end
    press(7);
    tests_run++;
    if (entry_error !== 1'b1 || {d5, d4, d3, d2, d1, d0} !== 24'h453210) begin
      tests_failed++;
      $display("FAIL overflow_error: got err=%b digits=%h, expected err=1 digits=453210", entry_error, {d5, d4, d3, d2, d1, d0});
    end
    @(negedge clk);
    tests_run++;
    if (entry_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL error_pulse_width: got err=%b one cycle later, expected 0", entry_error);
    end
  endtask

  task automatic test_backspace_short_enter();
    press(11); press(1); press(2); press(3); press(10); press(9);
    tests_run++;
    if ({d5, d4, d3, d2, d1, d0} !== 24'h000129 || digit_count !== 3'd3) begin
      tests_failed++;
      $display("FAIL backspace_edit: got %h count=%0d, expected 000129 count=3", {d5, d4, d3, d2, d1, d0}, digit_count);
    end
    press(12);
    tests_run++;
    if (entry_error !== 1'b1 || start !== 1'b0) begin
      tests_failed++;
      $display("FAIL short_enter: got err=%b start=%b, expected err=1 start=0", entry_error, start);
    end
    press(11); press(10);
    tests_run++;
    if (digit_count !== 3'd0 || entry_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL backspace_empty: got count=%0d err=%b, expected count=0 err=0", digit_count, entry_error);
    end
  endtask

  task automatic test_search_found();
    int hi_cycles = 0;
    for (int i = 0; i < 6; i++) press(9 - i);
    press(12);
    tests_run++;
    if (start !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL launch: got start=%b busy=%b, expected 1 1", start, busy);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (start === 1'b1) hi_cycles++;
    end
    tests_run++;
    if (hi_cycles != 10) begin
      tests_failed++;
      $display("FAIL start_hold: got start high %0d of 10 cycles, expected 10", hi_cycles);
    end
    done = 1'b1; found = 1'b1;
    @(negedge clk);
    tests_run++;
    if (start !== 1'b0 || busy !== 1'b1 || result_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_seen: got start=%b busy=%b rv=%b, expected 0 1 0", start, busy, result_valid);
    end
    done = 1'b0; found = 1'b0;
    @(negedge clk);
    mstate = 2; mvalid = 1; mfound = 1; mtimeout = 0;
    tests_run++;
    if (result_valid !== 1'b1 || result_found !== 1'b1 || busy !== 1'b0 || timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL result_found: got rv=%b rf=%b busy=%b to=%b, expected 1 1 0 0", result_valid, result_found, busy, timeout);
    end
  endtask

  task automatic test_timeout();
    int hi_cycles = 0;
    press(11);
    for (int i = 0; i < 6; i++) press(i + 1);
    press(12);
    while (start === 1'b1 && hi_cycles < 40) begin
      hi_cycles++;
      @(negedge clk);
    end
    tests_run++;
    if (hi_cycles != 16) begin
      tests_failed++;
      $display("FAIL watchdog_length: got start high %0d cycles, expected 16", hi_cycles);
    end
    @(negedge clk);
    mstate = 2; mvalid = 1; mfound = 0; mtimeout = 1;
    tests_run++;
    if (result_valid !== 1'b1 || result_found !== 1'b0 || timeout !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_result: got rv=%b rf=%b to=%b busy=%b, expected 1 0 1 0", result_valid, result_found, timeout, busy);
    end
  endtask

  task automatic test_result_keys();
    press(8);
    tests_run++;
    if (result_valid !== 1'b0 || timeout !== 1'b0 || {d5, d4, d3, d2, d1, d0} !== 24'h000008 || digit_count !== 3'd1) begin
      tests_failed++;
      $display("FAIL result_digit: got rv=%b to=%b digits=%h count=%0d, expected 0 0 000008 1",
               result_valid, timeout, {d5, d4, d3, d2, d1, d0}, digit_count);
    end
    for (int i = 0; i < 5; i++) press(i + 3);
    press(12);
    do_search(1'b0);
    press(12);
    tests_run++;
    if (start !== 1'b1 || result_valid !== 1'b0 || {d5, d4, d3, d2, d1, d0} !== 24'h834567) begin
      tests_failed++;
      $display("FAIL research: got start=%b rv=%b digits=%h, expected 1 0 834567", start, result_valid, {d5, d4, d3, d2, d1, d0});
    end
    do_search(1'b1);
    press(10);
    tests_run++;
    if (result_valid !== 1'b0 || {d5, d4, d3, d2, d1, d0} !== 24'h083456 || digit_count !== 3'd5) begin
      tests_failed++;
      $display("FAIL result_backspace: got rv=%b digits=%h count=%0d, expected 0 083456 5",
               result_valid, {d5, d4, d3, d2, d1, d0}, digit_count);
    end
  endtask

  task automatic test_reset_midsearch();
    press(11);
    for (int i = 0; i < 6; i++) press(7);
    press(12);
    press(3);
    press(11);
    press(12);
    tests_run++;
    if (entry_error !== 1'b0 || {d5, d4, d3, d2, d1, d0} !== 24'h777777 || start !== 1'b1) begin
      tests_failed++;
      $display("FAIL keys_in_launch: got err=%b digits=%h start=%b, expected 0 777777 1",
               entry_error, {d5, d4, d3, d2, d1, d0}, start);
    end
    apply_reset();
    tests_run++;
    if ({d5, d4, d3, d2, d1, d0, digit_count, start, busy, result_valid, result_found, timeout, entry_error} !== 34'd0) begin
      tests_failed++;
      $display("FAIL reset_midsearch: got digits=%h count=%0d start=%b busy=%b, expected all zero",
               {d5, d4, d3, d2, d1, d0}, digit_count, start, busy);
    end
    press(5);
    tests_run++;
    if ({d5, d4, d3, d2, d1, d0} !== 24'h000005 || digit_count !== 3'd1 || start !== 1'b0) begin
      tests_failed++;
      $display("FAIL entry_after_reset: got digits=%h count=%0d start=%b, expected 000005 1 0",
               {d5, d4, d3, d2, d1, d0}, digit_count, start);
    end
  endtask

  task automatic test_random();
    int r, code;
    bit f;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 21);
      if (r < 10) code = r;
      else if (r < 13) code = 10;
      else if (r < 14) code = 11;
      else if (r < 17) code = 12;
      else code = $urandom_range(13, 31);
      press(code);
      tests_run++;
      if ({d5, d4, d3, d2, d1, d0} !== exp_digits() || digit_count !== 3'(q.size()) || entry_error !== merr ||
          start !== (mstate == 1) || result_valid !== mvalid || timeout !== mtimeout) begin
        tests_failed++;
        $display("FAIL random_key[%0d] code=%0d: got digits=%h count=%0d err=%b start=%b rv=%b to=%b, expected %h %0d %b %b %b %b",
                 n, code, {d5, d4, d3, d2, d1, d0}, digit_count, entry_error, start, result_valid, timeout,
                 exp_digits(), q.size(), merr, (mstate == 1), mvalid, mtimeout);
      end
      if (mstate == 1) begin
        f = 1'($urandom_range(0, 1));
        do_search(f);
        tests_run++;
        if (result_valid !== 1'b1 || result_found !== mfound || busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL random_search[%0d]: got rv=%b rf=%b busy=%b, expected 1 %b 0", n, result_valid, result_found, busy, mfound);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_code = 5'd0; done = 1'b0; found = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_overflow();
    test_backspace_short_enter();
    test_search_found();
    test_timeout();
    test_result_keys();
    test_reset_midsearch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bin_digit_entry.md
Name: bin_digit_entry

Overview:
Upstream front end for the BIN binary-search engine. Collects keypad digit strobes into a 6-digit BIN (d5 = most significant) and supports backspace and clear. Drives the searcher's level start/done handshake and latches the search result for the display stage. Includes a watchdog so a stalled searcher cannot lock up entry.

Parameters:
NUM_DIGITS, 6, digits required before enter is accepted; fixed at 6 to match the searcher.
TIMEOUT_CYCLES, 4096, maximum cycles start may stay high without done before the search is aborted; must be at least 2.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
key_valid  input  1  one-cycle strobe; key_code is valid this cycle
key_code  input  5  0-9 digit, 10 backspace, 11 clear, 12 enter; 13-31 ignored
done  input  1  searcher done level
found  input  1  searcher found flag; sampled only when done=1
d5,d4,d3,d2,d1,d0  output  4 each  BCD digits to searcher, d5 MSD
start  output  1  search request level to searcher
digit_count  output  3  number of digits entered, 0..6
busy  output  1  high in LAUNCH and RELEASE states
result_valid  output  1  high while a completed search result is held
result_found  output  1  latched found value; meaningful when result_valid=1
timeout  output  1  high with result_valid when the last search was aborted by watchdog
entry_error  output  1  one-cycle pulse: enter with digit_count<6, or digit with digit_count=6

Behaviour:
- All outputs are registered. Reset values: d5..d0=0, digit_count=0, start=0, busy=0, result_valid=0, result_found=0, timeout=0, entry_error=0. State=ENTRY, watchdog counter=0.
- Reset is synchronous and overrides everything, including mid-search. start falls at the reset edge.
- States:
  - ENTRY: accept and edit digits.
  - LAUNCH: start=1; wait for done.
  - RELEASE: start=0; wait for done=0.
  - RESULT: hold the result; accept keys.
- Key timing: key_valid at edge n takes effect at edge n+1. Digit outputs and state are updated then.
- ENTRY, digit key with count<6: shift left (d5<=d4 ... d1<=d0, d0<=digit), then count+1.
- ENTRY, digit key with count=6: digits unchanged; entry_error pulses.
- ENTRY, backspace with count>0: shift right (d0<=d1 ... d4<=d5, d5<=0), then count-1.
- ENTRY, backspace with count=0: no action, no error.
- ENTRY, clear: all digits=0, count=0.
- ENTRY, enter with count=6: go to LAUNCH; start=1 and busy=1 from the next edge; watchdog counter cleared.
- ENTRY, enter with count<6: entry_error pulses; state unchanged.
- LAUNCH:
  - Watchdog counter increments each cycle.
  - done=1: result_found<=found, timeout<=0, start<=0, go to RELEASE.
  - Counter reaches TIMEOUT_CYCLES-1 with done=0: result_found<=0, timeout<=1, start<=0, go to RELEASE.
  - done and watchdog expiry in the same cycle: done wins.
- RELEASE: when done=0, go to RESULT; result_valid<=1, busy<=0. If the searcher never drops done, stay in RELEASE until reset.
- LAUNCH and RELEASE ignore all keys. No entry_error is raised in these states.
- RESULT, digit key: result_valid<=0, timeout<=0, d5..d1=0, d0=digit, count=1, go to ENTRY.
- RESULT, backspace: result_valid<=0, normal backspace applied (count becomes 5), go to ENTRY.
- RESULT, clear: result_valid<=0, digits and count cleared, go to ENTRY.
- RESULT, enter: result_valid<=0, timeout<=0, go to LAUNCH with the same digits (re-search).
- Codes 13-31 are ignored in every state and never raise entry_error.
- Digit outputs are stable whenever start=1; the searcher samples them one cycle after start rises.
- Watchdog counter width is clog2(TIMEOUT_CYCLES); it saturates and does not wrap.

Test Plan:
1. Reset, then keys 4,5,3,2,1,0 → d5..d0=4,5,3,2,1,0 and digit_count=6. Next digit key 7 → entry_error pulses one cycle; digits unchanged.
2. Keys 1,2,3, backspace, 9 → d2..d0=1,2,9, d5..d3=0, count=3. Enter → entry_error pulses; start stays 0.
3. Six digits, then enter → start=1 on the next edge. Model asserts done=1, found=1 after 10 cycles → start=0 next edge. Model drops done → result_valid=1, result_found=1, busy=0, timeout=0.
4. Six digits, enter, model never asserts done (TIMEOUT_CYCLES=16) → start drops after 16 cycles of start high; then result_valid=1, result_found=0, timeout=1.
5. In RESULT, digit 8 → result_valid=0, d0=8, others 0, count=1. In RESULT, enter → relaunch with start=1 on the next edge and the original digits retained.
6. Reset pulsed during LAUNCH with start=1 → next edge: start=0, all outputs 0, state=ENTRY. Keys during LAUNCH → ignored, no entry_error.
